// File: rtl/pipe_stage_reg.sv
// Generic ready/valid pipeline stage register.
// Holds one payload (SKID=0) or up to two payloads (SKID=1) split into DATA and CTRL.
// CTRL reads as zero whenever the stage presents a bubble, so a bubble can never write state.
// A synchronous flush kills every held entry. A saturating counter records stalled output cycles.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are both 1
// on that interface. Once out_valid is high it stays high, and out_data/out_ctrl stay
// unchanged, until out_fire occurs or a flush/reset kills the entry. in_ready may be
// high while in_valid is low; a payload offered while in_ready is low is not taken.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [1:0]        dbg_state
);

    localparam bit USE_SKID = (SKID != 0);

    // EMPTY: nothing held; FULL: main entry valid; FULL2: main and skid both valid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_FULL2 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  main_data_q, main_data_d;
    logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;
    logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
    logic               rdy_q, rdy_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               in_fire;

    // Output view of the held state; in_ready is a flop with the skid entry, combinational without it.
    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        out_data  = main_data_q;
        out_ctrl  = out_valid ? main_ctrl_q : '0;
        in_ready  = USE_SKID ? rdy_q : (!out_valid || out_ready);
        in_fire   = in_valid && in_ready;
        stall_cnt = stall_q;
        dbg_state = state_q;
    end

    // Next-state and payload movement; flush overrides every transition and drops in_fire.
    // Without the skid entry FULL2 is unreachable because in_ready is low whenever FULL stalls.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d     = ST_FULL;
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_ready) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_fire) begin
                        state_d     = ST_FULL2;
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL2: begin
                    if (out_ready) begin
                        state_d     = ST_FULL;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        rdy_d = (state_d != ST_FULL2);
    end

    // Saturating count of cycles where the output is offered but not taken (flush cycle included).
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // State, payload and counter registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            rdy_q       <= 1'b1;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            rdy_q       <= rdy_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, no skid, 4-bit counter) share one stimulus.
// A FIFO-occupancy model predicts every output; directed literals pin key moments.
module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_ready;

    logic [2:0]    o_valid;
    logic [2:0]    o_ready;
    logic [DW-1:0] o_data [3];
    logic [CW-1:0] o_ctrl [3];
    logic [15:0]   sc0, sc1;
    logic [3:0]    sc2;
    logic [1:0]    dbg0, dbg1, dbg2;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // model: per-instance FIFO of accepted payloads plus a saturating stall count
    logic [DW-1:0] m_data [3][2];
    logic [CW-1:0] m_ctrl [3][2];
    int            m_cnt   [3];
    int            m_stall [3];
    int            m_max   [3];
    bit            m_skid  [3];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_s1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(o_ready[0]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(o_valid[0]), .out_ready(out_ready),
        .out_data(o_data[0]), .out_ctrl(o_ctrl[0]), .stall_cnt(sc0), .dbg_state(dbg0));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_s0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(o_ready[1]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(o_valid[1]), .out_ready(out_ready),
        .out_data(o_data[1]), .out_ctrl(o_ctrl[1]), .stall_cnt(sc1), .dbg_state(dbg1));

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_c4 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(o_ready[2]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(o_valid[2]), .out_ready(out_ready),
        .out_data(o_data[2]), .out_ctrl(o_ctrl[2]), .stall_cnt(sc2), .dbg_state(dbg2));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_rdy(input int i);
        if (m_skid[i]) return (m_cnt[i] < 2);
        return (m_cnt[i] == 0) || out_ready;
    endfunction

    function automatic logic [15:0] act_stall(input int i);
        case (i)
            0:       return sc0;
            1:       return sc1;
            default: return {12'd0, sc2};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_cnt[i]   = 0;
            m_stall[i] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_advance();
        bit rdy, fire, ofire;
        for (int i = 0; i < 3; i++) begin
            rdy   = exp_rdy(i);
            fire  = in_valid && rdy;
            ofire = (m_cnt[i] > 0) && out_ready;
            if (m_cnt[i] > 0 && !out_ready && m_stall[i] < m_max[i]) m_stall[i]++;
            if (flush) begin
                m_cnt[i] = 0;
            end else begin
                if (ofire) begin
                    m_data[i][0] = m_data[i][1];
                    m_ctrl[i][0] = m_ctrl[i][1];
                    m_cnt[i]--;
                end
                if (fire) begin
                    m_data[i][m_cnt[i]] = in_data;
                    m_ctrl[i][m_cnt[i]] = in_ctrl;
                    m_cnt[i]++;
                end
            end
        end
    endtask

    // compare process: every falling edge, every instance against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d out_valid", i), 128'(o_valid[i]), 128'(m_cnt[i] > 0));
                chk($sformatf("u%0d out_ctrl", i), 128'(o_ctrl[i]),
                    (m_cnt[i] > 0) ? 128'(m_ctrl[i][0]) : 128'd0);
                if (m_cnt[i] > 0)
                    chk($sformatf("u%0d out_data", i), 128'(o_data[i]), 128'(m_data[i][0]));
                chk($sformatf("u%0d in_ready", i), 128'(o_ready[i]), 128'(exp_rdy(i)));
                chk($sformatf("u%0d stall_cnt", i), 128'(act_stall(i)), 128'(m_stall[i]));
            end
        end
    end

    task automatic drive(input bit v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input bit ordy, input bit fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
    endtask

    // one clock: model steps with the edge, returns just after the compare point
    task automatic cycle();
        model_advance();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] pat_rdy;
        logic [15:0] pat_val;
        m_skid[0] = 1'b1; m_skid[1] = 1'b0; m_skid[2] = 1'b1;
        m_max[0]  = 65535; m_max[1] = 65535; m_max[2] = 15;
        reset = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        model_reset();
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset out_valid", 128'(o_valid), 128'd0);
        chk("reset in_ready", 128'(o_ready), 128'h7);
        chk("reset out_data", 128'(o_data[0]), 128'd0);
        chk("reset stall_cnt", 128'(sc0), 128'd0);
        reset = 1'b0;

        // streaming at full throughput
        drive(1'b1, 96'h11, 16'h0101, 1'b1, 1'b0); cycle();
        chk("t1 data0", 128'(o_data[0]), 128'h11);
        chk("t1 valid0", 128'(o_valid[0]), 128'd1);
        drive(1'b1, 96'h22, 16'h0102, 1'b1, 1'b0); cycle();
        chk("t1 data1", 128'(o_data[0]), 128'h22);
        chk("t1 ready", 128'(o_ready[0]), 128'd1);
        drive(1'b1, 96'h33, 16'h0103, 1'b1, 1'b0); cycle();
        chk("t1 data2", 128'(o_data[0]), 128'h33);
        drive(1'b0, '0, '0, 1'b1, 1'b0); cycle(); cycle();

        // back-pressure fills the skid entry
        drive(1'b1, 96'hA, 16'h00A1, 1'b0, 1'b0); cycle();
        chk("t2 A shown", 128'(o_data[0]), 128'hA);
        drive(1'b1, 96'hB, 16'h00B2, 1'b0, 1'b0); cycle();
        chk("t2 ready low", 128'(o_ready[0]), 128'd0);
        chk("t2 stall1", 128'(sc0), 128'd1);
        chk("t2 A held", 128'(o_data[0]), 128'hA);
        drive(1'b0, '0, '0, 1'b0, 1'b0); cycle();
        chk("t2 stall2", 128'(sc0), 128'd2);
        drive(1'b0, '0, '0, 1'b1, 1'b0); cycle();
        chk("t2 B shown", 128'(o_data[0]), 128'hB);
        chk("t2 ready back", 128'(o_ready[0]), 128'd1);
        cycle();
        chk("t2 drained", 128'(o_valid[0]), 128'd0);

        // flush while FULL2 with a live input
        drive(1'b1, 96'hC, 16'h00C3, 1'b0, 1'b0); cycle();
        drive(1'b1, 96'hD, 16'h00D4, 1'b0, 1'b0); cycle();
        drive(1'b1, 96'hE, 16'hFFFF, 1'b0, 1'b1); cycle();
        chk("t3 valid", 128'(o_valid[0]), 128'd0);
        chk("t3 ctrl", 128'(o_ctrl[0]), 128'd0);
        chk("t3 ready", 128'(o_ready[0]), 128'd1);
        chk("t3 stall counts flush", 128'(sc0), 128'd4);
        drive(1'b0, '0, '0, 1'b1, 1'b0); cycle(); cycle();
        chk("t3 nothing leaks", 128'(o_valid[0]), 128'd0);

        // combinational in_ready without skid, then mixed ready/valid pattern
        drive(1'b1, 96'h40, 16'h0040, 1'b0, 1'b0); cycle();
        out_ready = 1'b0; #1;
        chk("t4 s0 ready low", 128'(o_ready[1]), 128'd0);
        out_ready = 1'b1; #1;
        chk("t4 s0 ready mirrors", 128'(o_ready[1]), 128'd1);
        pat_rdy = 16'b1011_0110_1101_0011;
        pat_val = 16'b1111_1101_0111_1110;
        for (int k = 0; k < 16; k++) begin
            drive(pat_val[k], DW'(32'h100 + k), CW'(16'h0200 + k), pat_rdy[k], 1'b0);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0); cycle(); cycle(); cycle();

        // counter saturation on the 4-bit instance, then reset clears it
        drive(1'b1, 96'h55, 16'h0055, 1'b0, 1'b0); cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (20) cycle();
        chk("t5 saturated", 128'(sc2), 128'd15);
        reset = 1'b1;
        model_reset();
        #1;
        chk("t5 cleared", 128'(sc2), 128'd0);
        @(negedge clk); #1;
        reset = 1'b0;

        // asynchronous reset between edges while full
        drive(1'b1, 96'h66, 16'h0066, 1'b0, 1'b0); cycle();
        drive(1'b1, 96'h77, 16'h0077, 1'b0, 1'b0); cycle();
        model_advance();
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("t6 valid", 128'(o_valid), 128'd0);
        chk("t6 ctrl", 128'(o_ctrl[0]), 128'd0);
        chk("t6 data", 128'(o_data[0]), 128'd0);
        chk("t6 stall", 128'(sc0), 128'd0);
        chk("t6 ready", 128'(o_ready), 128'h7);
        @(negedge clk); #1;
        reset = 1'b0;
        drive(1'b0, '0, '0, 1'b1, 1'b0); cycle();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
